// File: rtl/sipo_frame_deframer_if.sv
// Nibble stream handshake between the deframer FIFO head and a nibble-wide consumer.
// The master presents data/last/valid; the slave answers with ready.
interface sipo_frame_deframer_if;
    logic [3:0] nib_data;
    logic       nib_last;
    logic       nib_valid;
    logic       nib_ready;

    modport master (output nib_data, output nib_last, output nib_valid, input  nib_ready);
    modport slave  (input  nib_data, input  nib_last, input  nib_valid, output nib_ready);
endinterface

// File: rtl/sipo_frame_deframer.sv
// Hunts the 4-bit shift-register taps for a sync word, then slices the following bits into
// fixed-length frames of nibbles delivered through a first-word-fall-through FIFO.
module sipo_frame_deframer #(
    parameter logic [3:0] SYNC_PATTERN      = 4'b1011,
    parameter int         NIBBLES_PER_FRAME = 4,
    parameter int         FIFO_DEPTH        = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        bit_en,
    input  logic [3:0]                  q_par,
    sipo_frame_deframer_if.master       nib,
    output logic                        locked,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fill
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_IDX = 4'(NIBBLES_PER_FRAME - 1);
    localparam logic [AW:0] DEPTH_V = FIFO_DEPTH[AW:0];

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t     state, state_next;
    logic [1:0] bit_cnt, bit_cnt_next;
    logic [3:0] nib_cnt, nib_cnt_next;
    logic       push_req, push_last;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours regardless of process order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= HUNT;
            bit_cnt <= '0;
            nib_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            nib_cnt <= nib_cnt_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        nib_cnt_next = nib_cnt;
        push_req     = 1'b0;
        push_last    = 1'b0;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    if (q_par == SYNC_PATTERN) begin
                        state_next   = LOCKED;
                        bit_cnt_next = '0;
                        nib_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    bit_cnt_next = bit_cnt + 2'd1;
                    // Fourth bit of a nibble: the taps now hold one whole payload nibble.
                    if (bit_cnt == 2'd3) begin
                        push_req     = 1'b1;
                        push_last    = (nib_cnt == LAST_IDX);
                        nib_cnt_next = nib_cnt + 4'd1;
                        if (push_last) begin
                            state_next   = HUNT;
                            bit_cnt_next = '0;
                            nib_cnt_next = '0;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCKED);

    logic [4:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [4:0]  head;
    logic        empty, full, pop, do_push;

    assign fill    = wr_ptr - rd_ptr;
    assign empty   = (fill == '0);
    assign full    = (fill == DEPTH_V);
    assign pop     = nib.nib_valid & nib.nib_ready;
    assign do_push = push_req & (~full | pop);

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers alone and
    // the head is masked while empty, so stale contents are never observable.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {push_last, q_par};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign nib.nib_valid = ~empty;
    assign nib.nib_data  = empty ? 4'h0 : head[3:0];
    assign nib.nib_last  = empty ? 1'b0 : head[4];

endmodule
